// File: rtl/clk_pkg.sv
// Shared clock-datapath definitions: BCD digit type and BCD/binary helpers
// used by the modulo counters and their validity checks.
package clk_pkg;

    localparam int         MAX_DIGITS = 6;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    typedef logic [3:0]              bcd_digit_t;
    typedef logic [4*MAX_DIGITS-1:0] bcd_word_t;

    // Decimal value of a packed BCD word; digit 0 sits in bits [3:0].
    function automatic int unsigned bcd_to_bin(input bcd_word_t bcd);
        int unsigned acc;
        acc = 32'd0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            acc = (acc * 32'd10) + 32'(bcd[4*k +: 4]);
        end
        return acc;
    endfunction

    // Packed BCD encoding of a binary value (used for elaboration constants).
    function automatic bcd_word_t bin_to_bcd(input int unsigned value);
        bcd_word_t   res;
        int unsigned rem;
        res = '0;
        rem = value;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            res[4*k +: 4] = 4'(rem % 32'd10);
            rem           = rem / 32'd10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of a modulo counter. Increments wrap 9->0 and decrements
// wrap 0->9; the carry/borrow outputs enable the next digit up.
module bcd_digit
    import clk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       inc,
    input  logic       dec,
    input  logic       carry_in,
    input  logic       borrow_in,
    output logic       carry_out,
    output logic       borrow_out,
    output bcd_digit_t q
);

    bcd_digit_t q_r;

    assign carry_out  = inc & carry_in  & (q_r == BCD_MAX);
    assign borrow_out = dec & borrow_in & (q_r == 4'd0);
    assign q          = q_r;

    // Digit register: clear beats load, load beats counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= load_val;
        end else if (inc && carry_in) begin
            q_r <= (q_r == BCD_MAX) ? 4'd0 : (q_r + 4'd1);
        end else if (dec && borrow_in) begin
            q_r <= (q_r == 4'd0) ? BCD_MAX : (q_r - 4'd1);
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down count, clear, checked parallel
// load, registered wrap pulse and combinational terminal count for cascading.
module bcd_mod_counter
    import clk_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                co,
    output logic                load_err
);

    localparam int          W        = 4 * DIGITS;
    localparam int unsigned MAX_BIN  = 32'(MODULUS - 1);
    localparam bcd_word_t   MAX_WORD = bin_to_bcd(MAX_BIN);
    localparam logic [W-1:0] MAX_BCD = MAX_WORD[W-1:0];

    if ((DIGITS < 1) || (DIGITS > MAX_DIGITS)) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be in 1..6");
    end
    if ((MODULUS < 2) || (MODULUS > 10**DIGITS)) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..10**DIGITS");
    end

    logic [W-1:0] count_s;
    logic         at_max_s;
    logic         at_zero_s;
    logic         lv_digits_ok_s;
    logic         lv_in_range_s;
    logic         load_ok_s;
    logic         wrap_s;
    logic         step_s;
    logic         inc_s;
    logic         dec_s;
    logic         dig_load_s;
    logic [W-1:0] dig_load_val_s;
    logic [1:0]   chain_unused_s;
    logic         co_r;
    logic         load_err_r;

    // Load value must be pure BCD and lie below the modulus.
    always_comb begin
        lv_digits_ok_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > BCD_MAX) begin
                lv_digits_ok_s = 1'b0;
            end else begin
                lv_digits_ok_s = lv_digits_ok_s;
            end
        end
        lv_in_range_s = (bcd_to_bin(bcd_word_t'(load_val)) <= MAX_BIN);
        load_ok_s     = lv_digits_ok_s & lv_in_range_s;
    end

    // Terminal detection, wrap override and per-digit step/load controls.
    always_comb begin
        at_max_s   = (count_s == MAX_BCD);
        at_zero_s  = (count_s == {W{1'b0}});
        wrap_s     = en & ~clr & ~load & (up_dn ? at_max_s : at_zero_s);
        step_s     = en & ~clr & ~load & ~wrap_s;
        inc_s      = step_s & up_dn;
        dec_s      = step_s & ~up_dn;
        dig_load_s = (load & ~clr & load_ok_s) | wrap_s;
        if (wrap_s) begin
            dig_load_val_s = up_dn ? {W{1'b0}} : MAX_BCD;
        end else begin
            dig_load_val_s = load_val;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic       cin_s;
        logic       bin_s;
        logic       cout_s;
        logic       bout_s;
        bcd_digit_t q_s;

        if (k == 0) begin : g_first
            assign cin_s = 1'b1;
            assign bin_s = 1'b1;
        end else begin : g_next
            assign cin_s = g_digit[k-1].cout_s;
            assign bin_s = g_digit[k-1].bout_s;
        end

        bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .load       (dig_load_s),
            .load_val   (dig_load_val_s[4*k +: 4]),
            .inc        (inc_s),
            .dec        (dec_s),
            .carry_in   (cin_s),
            .borrow_in  (bin_s),
            .carry_out  (cout_s),
            .borrow_out (bout_s),
            .q          (q_s)
        );

        assign count_s[4*k +: 4] = q_s;
    end

    // The top digit's carry/borrow has nowhere to go; wrap is decided by the modulus compare.
    assign chain_unused_s = {g_digit[DIGITS-1].cout_s, g_digit[DIGITS-1].bout_s};

    // One-cycle pulses: wrap accompanies the wrapped value, load_err flags a rejected load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co_r       <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            co_r       <= wrap_s;
            load_err_r <= load & ~clr & ~load_ok_s;
        end
    end

    assign count    = count_s;
    assign tc       = up_dn ? at_max_s : at_zero_s;
    assign co       = co_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: a mod-60 stage (A) cascaded into a
// mod-24 stage (H), plus a standalone mod-24 (B) and a 3-digit mod-1000 (C).
module tb_bcd_mod_counter;
    import clk_pkg::*;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        up_dn  = 1'b1;
    logic        clr    = 1'b0;
    logic        load   = 1'b0;
    logic [11:0] lv     = 12'h000;
    logic [7:0]  lv_h   = 8'h00;

    logic [7:0]  cnt_a, cnt_b, cnt_h;
    logic [11:0] cnt_c;
    logic        tc_a, tc_b, tc_c, tc_h;
    logic        co_a, co_b, co_c, co_h;
    logic        err_a, err_b, err_c, err_h;
    logic        en_h;

    assign en_h = en & tc_a;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_a), .tc(tc_a), .co(co_a), .load_err(err_a));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_b), .tc(tc_b), .co(co_b), .load_err(err_b));
    bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_c), .tc(tc_c), .co(co_c), .load_err(err_c));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_h (
        .clk(clk), .rst_n(rst_n), .en(en_h), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv_h), .count(cnt_h), .tc(tc_h), .co(co_h), .load_err(err_h));

    typedef struct {
        logic [11:0] cnt;
        logic        co;
        logic        err;
        logic        tc;
    } exp_t;

    exp_t        sb_q[4][$];
    int unsigned mval[4];
    int unsigned mmod[4] = '{60, 24, 1000, 24};
    int          mdig[4] = '{2, 2, 3, 2};
    int          n_checks = 0;
    int          n_errors = 0;

    logic [11:0] act_cnt[4];
    logic [3:0]  act_co, act_err, act_tc;
    assign act_cnt[0] = {4'h0, cnt_a};
    assign act_cnt[1] = {4'h0, cnt_b};
    assign act_cnt[2] = cnt_c;
    assign act_cnt[3] = {4'h0, cnt_h};
    assign act_co  = {co_h, co_c, co_b, co_a};
    assign act_err = {err_h, err_c, err_b, err_a};
    assign act_tc  = {tc_h, tc_c, tc_b, tc_a};

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit lv_ok(input logic [11:0] v, input int nd, input int unsigned m);
        logic [3:0] dg;
        for (int k = 0; k < nd; k++) begin
            dg = v[4*k +: 4];
            if (dg > 4'd9) return 1'b0;
        end
        return bcd_to_bin(bcd_word_t'(v)) < m;
    endfunction

    function automatic exp_t mk_exp(input int d, input logic co_i, input logic err_i);
        exp_t e;
        e.cnt = to_bcd(mval[d]);
        e.co  = co_i;
        e.err = err_i;
        e.tc  = up_dn ? (mval[d] == mmod[d] - 1) : (mval[d] == 0);
        return e;
    endfunction

    // Reference model: one clock edge applied to all four counters.
    task automatic model_edge();
        logic        tc_a_m;
        logic        en_d, co_d, err_d;
        logic [11:0] lv_d;
        tc_a_m = up_dn ? (mval[0] == 59) : (mval[0] == 0);
        for (int d = 0; d < 4; d++) begin
            en_d  = (d == 3) ? (en & tc_a_m) : en;
            lv_d  = (d == 2) ? lv : ((d == 3) ? {4'h0, lv_h} : {4'h0, lv[7:0]});
            co_d  = 1'b0;
            err_d = 1'b0;
            if (!rst_n) begin
                mval[d] = 0;
            end else if (clr) begin
                mval[d] = 0;
            end else if (load) begin
                if (lv_ok(lv_d, mdig[d], mmod[d])) mval[d] = bcd_to_bin(bcd_word_t'(lv_d));
                else err_d = 1'b1;
            end else if (en_d) begin
                if (up_dn) begin
                    if (mval[d] == mmod[d] - 1) begin mval[d] = 0; co_d = 1'b1; end
                    else mval[d] = mval[d] + 1;
                end else begin
                    if (mval[d] == 0) begin mval[d] = mmod[d] - 1; co_d = 1'b1; end
                    else mval[d] = mval[d] - 1;
                end
            end
            sb_q[d].push_back(mk_exp(d, co_d, err_d));
        end
    endtask

    // One clocked step: drive inputs on the falling edge, model the rising edge.
    task automatic cyc(input logic r, input logic e, input logic u, input logic c,
                       input logic l, input logic [11:0] v, input logic [7:0] vh);
        @(negedge clk);
        rst_n = r; en = e; up_dn = u; clr = c; load = l; lv = v; lv_h = vh;
        @(posedge clk);
        model_edge();
    endtask

    // Asynchronous reset between edges; expectation is checked before any edge.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            mval[d] = 0;
            sb_q[d].push_back(mk_exp(d, 1'b0, 1'b0));
        end
    endtask

    // Monitor: compare every pending expectation shortly after each output event.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (sb_q[d].size() > 0) begin
                e = sb_q[d].pop_front();
                n_checks++;
                if (act_cnt[d] !== e.cnt || act_co[d] !== e.co ||
                    act_err[d] !== e.err || act_tc[d] !== e.tc) begin
                    n_errors++;
                    $display("FAIL dut%0d @%0t: got cnt=%h co=%b err=%b tc=%b, expected cnt=%h co=%b err=%b tc=%b",
                             d, $time, act_cnt[d], act_co[d], act_err[d], act_tc[d],
                             e.cnt, e.co, e.err, e.tc);
                end
            end
        end
    end

    initial begin
        logic [11:0] rv;
        logic [7:0]  rvh;
        int          r;
        for (int d = 0; d < 4; d++) mval[d] = 0;

        // Reset held for two edges, then release.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);

        // Reset mid-count at 37, then one enabled edge -> 01.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h037, 8'h37);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        reset_mid();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);

        // Up sweep from 00 through the wrap.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00);
        for (int i = 0; i < 62; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);

        // Down wrap from 00, then one more step.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);

        // Load acceptance and rejection.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h045, 8'h45);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h060, 8'h60);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h03A, 8'h3A);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);

        // Priority: clr over load over en.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h059, 8'h23);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h059, 8'h23);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h059, 8'h23);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 8'h10);

        // Cascade 23:59 -> 00:00 on one edge; 3-digit 999 -> 000.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h059, 8'h23);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h999, 8'h99);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r   = int'($urandom_range(0, 99));
            rv  = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 999)) : 12'($urandom);
            rvh = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 30)) : rv[7:0];
            cyc(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                (r < 3), (r >= 3 && r < 13), rv, rvh);
        end

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (sb_q[d].size() != 0) begin
                n_errors++;
                $display("FAIL drain dut%0d: %0d expectations left, expected 0", d, sb_q[d].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
